// File: rtl/alu_pkg.sv
// Shared types and widths for the nibble-serial ALU stage.
package alu_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 10;
  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_MUL = 3'b101, OP_SHL = 3'b110, OP_CMP = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_e;

  typedef enum logic [2:0] {N_ADD, N_SUB, N_AND, N_OR, N_XOR} nib_op_e;

  typedef struct packed {
    opcode_e         opc;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_req_t;

  // CMP rides on the subtractor: borrow gives a<b, a zero difference gives a==b.
  function automatic nib_op_e nib_op_of(opcode_e opc);
    case (opc)
      OP_SUB, OP_CMP: return N_SUB;
      OP_AND:         return N_AND;
      OP_OR:          return N_OR;
      OP_XOR:         return N_XOR;
      default:        return N_ADD;
    endcase
  endfunction
endpackage

// File: rtl/nibble_alu_4b.sv
// Combinational 4-bit slice: add/sub with carry/borrow chaining, plus bitwise ops.
module nibble_alu_4b
  import alu_pkg::*;
(
  input  nib_op_e          i_op,
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_res,
  output logic             o_cout
);
  logic [NIB_W:0] w_sum;

  always_comb begin
    w_sum  = '0;
    o_res  = '0;
    o_cout = 1'b0;
    case (i_op)
      N_ADD: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{NIB_W{1'b0}}, i_cin};
        o_res  = w_sum[NIB_W-1:0];
        o_cout = w_sum[NIB_W];
      end
      N_SUB: begin
        // top bit of the 5-bit difference is the borrow out
        w_sum  = {1'b0, i_a} - {1'b0, i_b} - {{NIB_W{1'b0}}, i_cin};
        o_res  = w_sum[NIB_W-1:0];
        o_cout = w_sum[NIB_W];
      end
      N_AND:   o_res = i_a & i_b;
      N_OR:    o_res = i_a | i_b;
      N_XOR:   o_res = i_a ^ i_b;
      default: o_res = '0;
    endcase
  end
endmodule

// File: rtl/alu_stage_4b.sv
// Multi-cycle ALU stage: low nibble then high nibble through one shared slice,
// 4-step shift-add for MUL, result held in DONE until the TX stage takes it.
module alu_stage_4b
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  input  logic [2:0]       opcode,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [RES_W-1:0] res_data,
  output logic             carry_out,
  output logic             res_valid,
  input  logic             res_ready
);
  state_e           r_state, w_next;
  op_req_t          r_req;
  logic [NIB_W-1:0] r_lo;
  logic             r_c;
  logic [1:0]       r_cnt;
  logic [OP_W-1:0]  r_acc;
  logic [RES_W-1:0] r_res;
  logic             r_cout;

  logic             w_hi;
  logic [NIB_W-1:0] w_nres;
  logic             w_ncout;
  logic             w_eq;
  logic [OP_W-1:0]  w_acc_nxt;
  logic [RES_W-1:0] w_shl;

  assign w_hi = (r_state == S_HI);

  nibble_alu_4b u_nib (
    .i_op   (nib_op_of(r_req.opc)),
    .i_a    (w_hi ? r_req.a[OP_W-1:NIB_W] : r_req.a[NIB_W-1:0]),
    .i_b    (w_hi ? r_req.b[OP_W-1:NIB_W] : r_req.b[NIB_W-1:0]),
    .i_cin  (w_hi ? r_c : 1'b0),
    .o_res  (w_nres),
    .o_cout (w_ncout)
  );

  assign w_eq      = (w_nres == '0) && (r_lo == '0);
  assign w_shl     = {2'b0, r_req.a} << r_req.b[1:0];
  assign w_acc_nxt = r_acc + (r_req.b[r_cnt] ? ({4'b0, r_req.a[NIB_W-1:0]} << r_cnt) : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (op_valid) w_next = (opcode_e'(opcode) == OP_MUL) ? S_MUL : S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_MUL:   if (r_cnt == 2'd3) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (r_state == S_IDLE);
    res_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= '0;
      r_lo   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_res  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (op_valid) begin
          r_req <= '{opc: opcode_e'(opcode), a: op_a, b: op_b};
          r_cnt <= '0;
          r_acc <= '0;
        end
        S_LO: begin
          r_lo <= w_nres;
          r_c  <= w_ncout;
        end
        S_HI: begin
          r_cout <= 1'b0;
          case (r_req.opc)
            OP_ADD: begin
              r_res  <= {1'b0, w_ncout, w_nres, r_lo};
              r_cout <= w_ncout;
            end
            OP_SUB: begin
              r_res  <= {2'b0, w_nres, r_lo};
              r_cout <= w_ncout;
            end
            OP_CMP: begin
              r_res  <= {8'b0, w_eq, w_ncout};
              r_cout <= w_ncout;
            end
            OP_SHL:  r_res <= w_shl;
            default: r_res <= {2'b0, w_nres, r_lo};
          endcase
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_res  <= {2'b0, w_acc_nxt};
            r_cout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data  = r_res;
  assign carry_out = r_cout;
endmodule

// File: tb/tb_alu_stage_4b.sv
// Directed-vector bench for alu_stage_4b: results, latency, backpressure, reset, streaming.
module tb_alu_stage_4b;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] op_a, op_b;
  logic [2:0] opcode;
  logic       op_valid, op_ready;
  logic [9:0] res_data;
  logic       carry_out, res_valid, res_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_stage_4b dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .op_valid(op_valid), .op_ready(op_ready), .res_data(res_data),
    .carry_out(carry_out), .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op from IDLE, measure edges from accept to res_valid, check, consume.
  task automatic run_op(input string tag, input logic [2:0] opc, input logic [7:0] a,
                        input logic [7:0] b, input logic [9:0] er, input logic ec,
                        input int elat);
    int lat;
    check({tag, "_rdy"}, op_ready, 1);
    opcode = opc; op_a = a; op_b = b; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, res_data, er);
    check({tag, "_cy"}, carry_out, ec);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle"}, op_ready, 1);
  endtask

  logic [2:0] bb_op [3];
  logic [7:0] bb_a  [3];
  logic [7:0] bb_b  [3];
  logic [9:0] bb_r  [3];
  int         acc_cyc [3];

  initial begin
    int seen, cyc, k_in, k_out;
    logic prev_rdy;
    logic [9:0] held;
    rst = 1'b1; op_a = '0; op_b = '0; opcode = '0; op_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_rdy", op_ready, 1);
    check("rst_vld", res_valid, 0);
    check("rst_res", res_data, 0);
    check("rst_cy",  carry_out, 0);

    run_op("add_ff01", 3'b000, 8'hFF, 8'h01, 10'h100, 1'b1, 2);
    run_op("sub_1020", 3'b001, 8'h10, 8'h20, 10'h0F0, 1'b1, 2);
    run_op("cmp_1020", 3'b111, 8'h10, 8'h20, 10'h001, 1'b1, 2);
    run_op("mul_0f0f", 3'b101, 8'h0F, 8'h0F, 10'h0E1, 1'b0, 4);
    run_op("shl_c302", 3'b110, 8'hC3, 8'h02, 10'h30C, 1'b0, 2);
    run_op("and",      3'b010, 8'hA5, 8'h3C, 10'h024, 1'b0, 2);
    run_op("or",       3'b011, 8'hA5, 8'h3C, 10'h0BD, 1'b0, 2);
    run_op("xor",      3'b100, 8'hA5, 8'h3C, 10'h099, 1'b0, 2);
    run_op("cmp_eq",   3'b111, 8'h55, 8'h55, 10'h002, 1'b0, 2);
    run_op("add_1234", 3'b000, 8'h12, 8'h34, 10'h046, 1'b0, 2);
    run_op("sub_300f", 3'b001, 8'h30, 8'h0F, 10'h021, 1'b0, 2);
    run_op("mul_7d3b", 3'b101, 8'h7D, 8'h3B, 10'h08F, 1'b0, 4);
    run_op("shl_ff03", 3'b110, 8'hFF, 8'h03, 10'h3F8, 1'b0, 2);
    run_op("add_ffff", 3'b000, 8'hFF, 8'hFF, 10'h1FE, 1'b1, 2);

    // Backpressure: hold res_ready low in DONE while a new op sits on the input.
    opcode = 3'b000; op_a = 8'h21; op_b = 8'h43; op_valid = 1'b1;
    tick();
    op_a = 8'h99; op_b = 8'h99; opcode = 3'b100;
    tick(); tick();
    check("bp_vld", res_valid, 1);
    held = res_data;
    check("bp_res", held, 10'h064);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", res_data, 10'h064);
      check("bp_nrdy", op_ready, 0);
      check("bp_vldh", res_valid, 1);
    end
    op_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_rel", op_ready, 1);
    check("bp_vld0", res_valid, 0);

    // Reset in HI: result must never surface.
    opcode = 3'b000; op_a = 8'hFF; op_b = 8'h01; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rhi_rdy", op_ready, 1);
    check("rhi_vld", res_valid, 0);
    check("rhi_res", res_data, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("rhi_ghost", seen, 0);

    // Reset in DONE: unconsumed result discarded.
    opcode = 3'b001; op_a = 8'h10; op_b = 8'h20; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick(); tick();
    check("rdn_vld1", res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rdn_rdy", op_ready, 1);
    check("rdn_vld", res_valid, 0);
    check("rdn_res", res_data, 0);
    check("rdn_cy",  carry_out, 0);

    // Back-to-back with op_valid and res_ready held high.
    bb_op[0] = 3'b000; bb_a[0] = 8'h01; bb_b[0] = 8'h02; bb_r[0] = 10'h003;
    bb_op[1] = 3'b100; bb_a[1] = 8'hF0; bb_b[1] = 8'h0F; bb_r[1] = 10'h0FF;
    bb_op[2] = 3'b001; bb_a[2] = 8'h05; bb_b[2] = 8'h03; bb_r[2] = 10'h002;
    k_in = 0; k_out = 0; cyc = 0;
    opcode = bb_op[0]; op_a = bb_a[0]; op_b = bb_b[0]; op_valid = 1'b1; res_ready = 1'b1;
    while (k_out < 3 && cyc < 60) begin
      prev_rdy = op_ready;
      tick();
      cyc++;
      if (prev_rdy && k_in < 3) begin
        acc_cyc[k_in] = cyc;
        k_in++;
        if (k_in < 3) begin
          opcode = bb_op[k_in]; op_a = bb_a[k_in]; op_b = bb_b[k_in];
        end else op_valid = 1'b0;
      end
      if (res_valid && k_out < 3) begin
        check("b2b_res", res_data, bb_r[k_out]);
        k_out++;
      end
    end
    op_valid = 1'b0; res_ready = 1'b0;
    check("b2b_cnt", k_out, 3);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 4);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
